// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/shift ops plus an iterative shift-and-add MUL,
// all behind a start/done handshake with registered y and NZCV flags.
module ula_multiciclo #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       Flags,
    output logic             busy,
    output logic             done
);
    localparam int SW = $clog2(WIDTH);
    localparam bit MUL_ON = (MUL_EN != 0);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_ASR = 3'b111;

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]        mcand, mplier, acc, acc_next;
    logic [SW-1:0]           cnt;
    logic [SW-1:0]           shamt;
    logic [WIDTH:0]          add_ext, sub_ext, lsl_ext, lsr_ext;
    logic signed [WIDTH:0]   asr_ext;
    logic [WIDTH-1:0]        op_y;
    logic                    op_c, op_v;
    logic                    accept_op, accept_mul, mul_last;

    // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
    assign shamt   = B[SW-1:0];
    assign add_ext = {1'b0, A} + {1'b0, B};
    assign sub_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign lsl_ext = {1'b0, A} << shamt;
    assign lsr_ext = {A, 1'b0} >> shamt;
    assign asr_ext = $signed({A, 1'b0}) >>> shamt;

    always_comb begin
        op_y = '0;
        op_c = 1'b0;
        op_v = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                op_y = add_ext[WIDTH-1:0];
                op_c = add_ext[WIDTH];
                op_v = (A[WIDTH-1] == B[WIDTH-1]) && (op_y[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                op_y = sub_ext[WIDTH-1:0];
                op_c = sub_ext[WIDTH];
                op_v = (A[WIDTH-1] != B[WIDTH-1]) && (op_y[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: op_y = A & B;
            OP_OR:  op_y = A | B;
            OP_LSL: begin
                op_y = lsl_ext[WIDTH-1:0];
                op_c = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                op_y = lsr_ext[WIDTH:1];
                op_c = lsr_ext[0];
            end
            OP_ASR: begin
                op_y = asr_ext[WIDTH:1];
                op_c = asr_ext[0];
            end
            default: op_y = '0;  // MUL with the multiplier disabled
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_next = state;
        accept_op  = 1'b0;
        accept_mul = 1'b0;
        mul_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (MUL_ON && ALUControl == OP_MUL) begin
                        accept_mul = 1'b1;
                        state_next = MUL;
                    end else begin
                        accept_op = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt == SW'(WIDTH - 1)) begin
                    mul_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Multiplicand shifts left and multiplier right so each iteration only looks at bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y      <= '0;
            Flags  <= '0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (accept_op) begin
                y     <= op_y;
                Flags <= {op_y[WIDTH-1], (op_y == '0), op_c, op_v};
                done  <= 1'b1;
            end
            if (accept_mul) begin
                mcand  <= A;
                mplier <= B;
                acc    <= '0;
                cnt    <= '0;
            end
            if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_last) begin
                    y     <= acc_next;
                    Flags <= {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
                    done  <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == MUL);

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo (WIDTH=32, MUL_EN=1): directed table, random ops
// against an arithmetic reference model, and handshake/reset corner sequences.
module tb_ula_multiciclo;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  ALUControl;
    logic [31:0] A, B;
    logic [31:0] y;
    logic [3:0]  Flags;
    logic        busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    ula_multiciclo #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ALUControl(ALUControl),
        .A(A), .B(B), .y(y), .Flags(Flags), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic on wide integers, flags straight from their definitions.
    function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        c, v;
        int          s;
        longint      u, sl;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        s = int'(b[4:0]);
        case (op)
            3'd0: begin
                u  = longint'(a) + longint'(b);
                r  = 32'(u);
                c  = (u >= 64'sh1_0000_0000);
                sl = longint'($signed(a)) + longint'($signed(b));
                v  = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
            end
            3'd1: begin
                r  = a - b;
                c  = (a >= b);
                sl = longint'($signed(a)) - longint'($signed(b));
                v  = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a * b;
            3'd5: begin
                r = a << s;
                c = (s == 0) ? 1'b0 : a[32 - s];
            end
            3'd6: begin
                r = a >> s;
                c = (s == 0) ? 1'b0 : a[s - 1];
            end
            default: begin
                r = 32'($signed(a) >>> s);
                c = (s == 0) ? 1'b0 : a[s - 1];
            end
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    // Issue one op, scramble the inputs right after the accept edge, wait for done.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ry, output logic [3:0] rf, output int lat);
        @(negedge clk);
        start      = 1'b1;
        ALUControl = op;
        A          = a;
        B          = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        A          = $urandom;
        B          = $urandom;
        ALUControl = 3'($urandom);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ry = y;
        rf = Flags;
    endtask

    initial begin
        logic [31:0] ry, ea, eb;
        logic [3:0]  rf;
        logic [35:0] exp;
        int          lat, pulses, done_at;
        logic        busy_seen;

        vecs[0]  = '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 0};
        vecs[1]  = '{3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110, 0};
        vecs[2]  = '{3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000, 0};
        vecs[3]  = '{3'd4, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 4'b0000, 32};
        vecs[4]  = '{3'd4, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0100, 32};
        vecs[5]  = '{3'd7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b1000, 0};
        vecs[6]  = '{3'd5, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0010, 0};
        vecs[7]  = '{3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000, 0};
        vecs[8]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 0};
        vecs[9]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 0};
        vecs[10] = '{3'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000, 0};
        vecs[11] = '{3'd6, 32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 4'b0110, 0};

        reset_n    = 1'b0;
        start      = 1'b0;
        ALUControl = 3'd0;
        A          = '0;
        B          = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", 64'(y), 64'd0);
        check("reset_flags", 64'(Flags), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, ry, rf, lat);
            check($sformatf("vec%0d_y", i), 64'(ry), 64'(vecs[i].y));
            check($sformatf("vec%0d_flags", i), 64'(rf), 64'(vecs[i].f));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // done must be a single-cycle pulse
        @(posedge clk);
        #1;
        check("done_pulse_low", 64'(done), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            ea = $urandom;
            eb = (i % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            if (i % 5 == 0) eb = ea;
            exp = ref_alu(op, ea, eb);
            do_op(op, ea, eb, ry, rf, lat);
            check($sformatf("rnd%0d_op%0d_y", i, op), 64'(ry), 64'(exp[35:4]));
            check($sformatf("rnd%0d_op%0d_flags", i, op), 64'(rf), 64'(exp[3:0]));
            check($sformatf("rnd%0d_lat", i), 64'(lat), (op == 3'd4) ? 64'd32 : 64'd0);
        end

        // start during a busy MUL is ignored
        @(negedge clk);
        start = 1'b1; ALUControl = 3'd4; A = 32'd1000; B = 32'd2000;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0; done_at = -1; busy_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                start = 1'b1; ALUControl = 3'd0; A = 32'd1; B = 32'd1;
            end
            if (i == 8) start = 1'b0;
            @(posedge clk);
            #1;
            if (i == 5) busy_seen = busy;
            if (done) begin
                pulses++;
                done_at = i;
            end
        end
        check("busy_during_mul", 64'(busy_seen), 64'd1);
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_done_at", 64'(done_at), 64'd32);
        check("ignore_y", 64'(y), 64'd2000000);

        // ADD issued in the done cycle of a MUL: accepted with no bubble
        do_op(3'd4, 32'd12, 32'd11, ry, rf, lat);
        check("b2b_mul_y", 64'(ry), 64'd132);
        start = 1'b1; ALUControl = 3'd0; A = 32'h0000_0100; B = 32'h0000_0023;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_add_done", 64'(done), 64'd1);
        check("b2b_add_y", 64'(y), 64'h123);
        @(posedge clk);
        #1;
        check("b2b_done_drop", 64'(done), 64'd0);

        // reset at MUL iteration 10 aborts the op
        @(negedge clk);
        start = 1'b1; ALUControl = 3'd4; A = 32'd5; B = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_y", 64'(y), 64'd0);
        check("abort_flags", 64'(Flags), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        do_op(3'd1, 32'h0000_0010, 32'h0000_0001, ry, rf, lat);
        check("after_reset_y", 64'(ry), 64'h0F);
        check("after_reset_flags", 64'(rf), 64'b0010);
        check("after_reset_lat", 64'(lat), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
